// File: rtl/stopwatch_ctrl_if.sv
// ---------------------------------------------------------------------------
// stopwatch_ctrl_if
// Bundles the button inputs and the count/status outputs of stopwatch_ctrl.
//   btn_ss  : raw start/stop button (asynchronous, active-high)
//   btn_clr : raw clear button (asynchronous, active-high)
//   Q       : current 4-bit count
//   pause   : high whenever the controller is not running
//   carry   : one-cycle pulse after a 15->0 wrap
//   state   : IDLE=0, RUN=1, PAUSED=2, DONE=3
// master drives the buttons and observes the outputs; slave is the controller.
// ---------------------------------------------------------------------------
interface stopwatch_ctrl_if;
  logic       btn_ss;
  logic       btn_clr;
  logic [3:0] Q;
  logic       pause;
  logic       carry;
  logic [1:0] state;

  modport master (
    output btn_ss,
    output btn_clr,
    input  Q,
    input  pause,
    input  carry,
    input  state
  );

  modport slave (
    input  btn_ss,
    input  btn_clr,
    output Q,
    output pause,
    output carry,
    output state
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// stopwatch_ctrl
// Run/pause/clear controller for a 4-bit count stage. Two raw buttons are
// synchronized and debounced; their rising edges drive a run/pause/clear FSM
// that gates a prescaler producing the count-enable tick for a 4-bit counter.
//   CLK   : single clock, all state on the rising edge
//   RST   : synchronous active-high reset
//   bus   : stopwatch_ctrl_if.slave (buttons in; Q, pause, carry, state out)
// Parameters:
//   PRESCALE : clock cycles per count tick (>= 2)
//   DEBOUNCE : stable synchronized cycles needed to accept a level change (>= 1)
//   WRAP     : 1 = count wraps 15->0 with carry; 0 = stop at 15 in DONE
// ---------------------------------------------------------------------------
module stopwatch_ctrl #(
  parameter int unsigned PRESCALE = 32'd50000000,
  parameter int unsigned DEBOUNCE = 32'd1000000,
  parameter bit          WRAP     = 1'b1
) (
  input  logic            CLK,
  input  logic            RST,
  stopwatch_ctrl_if.slave bus
);

  localparam int unsigned   PW      = $clog2(PRESCALE);
  localparam int unsigned   DW      = $clog2(DEBOUNCE + 32'd1);
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 32'd1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE - 32'd1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Button index 0 = start/stop, 1 = clear.
  logic [1:0]    raw_s;
  logic [1:0]    sync1_r;
  logic [1:0]    sync2_r;
  logic [1:0]    deb_r;
  logic [1:0]    deb_d_r;
  logic [DW-1:0] db_cnt_r [2];

  logic          ss_ev_s;
  logic          clr_ev_s;
  logic          tick_s;

  state_t        state_r;
  state_t        state_nxt_s;
  logic [3:0]    q_r;
  logic [3:0]    q_nxt_s;
  logic [PW-1:0] presc_r;
  logic [PW-1:0] presc_nxt_s;
  logic          carry_r;
  logic          carry_nxt_s;
  logic          pause_r;

  assign raw_s = {bus.btn_clr, bus.btn_ss};

  // Two-flop synchronizer plus per-button debounce counter.
  // The counter only runs while the synchronized level disagrees with the
  // accepted level, so any disagreement shorter than DEBOUNCE is discarded.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_r <= 2'b00;
      sync2_r <= 2'b00;
      deb_r   <= 2'b00;
      deb_d_r <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        db_cnt_r[i] <= {DW{1'b0}};
      end
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
      deb_d_r <= deb_r;
      for (int i = 0; i < 2; i++) begin
        if (sync2_r[i] != deb_r[i]) begin
          if (db_cnt_r[i] == DB_LAST) begin
            deb_r[i]    <= sync2_r[i];
            db_cnt_r[i] <= {DW{1'b0}};
          end else begin
            db_cnt_r[i] <= db_cnt_r[i] + DW'(1);
          end
        end else begin
          db_cnt_r[i] <= {DW{1'b0}};
        end
      end
    end
  end

  // Press events: rising edge of the debounced level; releases are silent.
  assign ss_ev_s  = deb_r[0] & ~deb_d_r[0];
  assign clr_ev_s = deb_r[1] & ~deb_d_r[1];
  assign tick_s   = (state_r == ST_RUN) && (presc_r == PS_LAST);

  // Next-state logic for FSM, prescaler, counter and carry.
  always_comb begin
    state_nxt_s = state_r;
    q_nxt_s     = q_r;
    presc_nxt_s = presc_r;
    carry_nxt_s = 1'b0;
    if (clr_ev_s) begin
      // Clear beats a simultaneous start/stop and any tick.
      state_nxt_s = ST_IDLE;
      q_nxt_s     = 4'd0;
      presc_nxt_s = {PW{1'b0}};
    end else begin
      // Prescaler holds in PAUSED so a resume keeps the partial period.
      case (state_r)
        ST_RUN: begin
          if (tick_s) begin
            presc_nxt_s = {PW{1'b0}};
          end else begin
            presc_nxt_s = presc_r + PW'(1);
          end
        end
        ST_PAUSED: presc_nxt_s = presc_r;
        default:   presc_nxt_s = {PW{1'b0}};
      endcase

      if (ss_ev_s) begin
        case (state_r)
          ST_IDLE:   state_nxt_s = ST_RUN;
          ST_RUN:    state_nxt_s = ST_PAUSED;
          ST_PAUSED: state_nxt_s = ST_RUN;
          default:   state_nxt_s = state_r;
        endcase
      end else begin
        state_nxt_s = state_r;
      end

      // A tick still counts on the edge a start/stop lands; reaching the
      // terminal count in non-wrapping mode overrides any pause request.
      if (tick_s) begin
        if (WRAP) begin
          q_nxt_s     = q_r + 4'd1;
          carry_nxt_s = (q_r == 4'd15);
        end else if (q_r >= 4'd14) begin
          q_nxt_s     = 4'd15;
          state_nxt_s = ST_DONE;
        end else begin
          q_nxt_s = q_r + 4'd1;
        end
      end else begin
        q_nxt_s = q_r;
      end
    end
  end

  // FSM and datapath registers; pause is registered from the next state so
  // it moves on the same edge as state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= ST_IDLE;
      q_r     <= 4'd0;
      presc_r <= {PW{1'b0}};
      carry_r <= 1'b0;
      pause_r <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      q_r     <= q_nxt_s;
      presc_r <= presc_nxt_s;
      carry_r <= carry_nxt_s;
      pause_r <= (state_nxt_s != ST_RUN);
    end
  end

  assign bus.Q     = q_r;
  assign bus.pause = pause_r;
  assign bus.carry = carry_r;
  assign bus.state = state_r;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_stopwatch_ctrl
// Two controllers (WRAP=1 as instance 0, WRAP=0 as instance 1) with
// PRESCALE=4, DEBOUNCE=3. Directed scenarios check timing points as
// constants; a random phase compares every cycle against a reference model.
// ---------------------------------------------------------------------------
module tb_stopwatch_ctrl;
  localparam int P = 4;
  localparam int D = 3;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSED = 2, S_DONE = 3;

  logic clk = 1'b0;
  logic rst;
  bit [1:0] ss_in;
  bit [1:0] clr_in;
  int tests_run = 0;
  int tests_failed = 0;

  stopwatch_ctrl_if bus_w ();
  stopwatch_ctrl_if bus_s ();

  assign bus_w.btn_ss  = ss_in[0];
  assign bus_w.btn_clr = clr_in[0];
  assign bus_s.btn_ss  = ss_in[1];
  assign bus_s.btn_clr = clr_in[1];

  stopwatch_ctrl #(.PRESCALE(P), .DEBOUNCE(D), .WRAP(1'b1)) u_wrap (.CLK(clk), .RST(rst), .bus(bus_w));
  stopwatch_ctrl #(.PRESCALE(P), .DEBOUNCE(D), .WRAP(1'b0)) u_stop (.CLK(clk), .RST(rst), .bus(bus_s));

  logic [3:0] dq [2];
  logic [1:0] dst [2];
  logic       dpause [2];
  logic       dcarry [2];
  assign dq[0] = bus_w.Q;         assign dq[1] = bus_s.Q;
  assign dst[0] = bus_w.state;    assign dst[1] = bus_s.state;
  assign dpause[0] = bus_w.pause; assign dpause[1] = bus_s.pause;
  assign dcarry[0] = bus_w.carry; assign dcarry[1] = bus_s.carry;

  always #5 clk = ~clk;

  // Reference model state
  int m_st [2];
  int m_q  [2];
  int m_ph [2];
  bit m_cy [2];
  bit m_s1 [2][2];
  bit m_s2 [2][2];
  bit m_deb [2][2];
  bit m_prev [2][2];
  int m_cnt [2][2];

  task automatic model_step();
    bit raw [2];
    bit ev_ss, ev_clr, tick;
    int ns;
    for (int i = 0; i < 2; i++) begin
      raw[0] = ss_in[i];
      raw[1] = clr_in[i];
      ev_ss  = m_deb[i][0] && !m_prev[i][0];
      ev_clr = m_deb[i][1] && !m_prev[i][1];
      if (rst) begin
        m_st[i] = S_IDLE; m_q[i] = 0; m_ph[i] = 0; m_cy[i] = 1'b0;
        for (int b = 0; b < 2; b++) begin
          m_s1[i][b] = 1'b0; m_s2[i][b] = 1'b0; m_deb[i][b] = 1'b0;
          m_prev[i][b] = 1'b0; m_cnt[i][b] = 0;
        end
      end else begin
        for (int b = 0; b < 2; b++) begin
          m_prev[i][b] = m_deb[i][b];
          if (m_s2[i][b] != m_deb[i][b]) begin
            m_cnt[i][b]++;
            if (m_cnt[i][b] == D) begin
              m_deb[i][b] = m_s2[i][b];
              m_cnt[i][b] = 0;
            end
          end else begin
            m_cnt[i][b] = 0;
          end
          m_s2[i][b] = m_s1[i][b];
          m_s1[i][b] = raw[b];
        end
        tick = (m_st[i] == S_RUN) && (m_ph[i] == P - 1);
        m_cy[i] = 1'b0;
        if (ev_clr) begin
          m_st[i] = S_IDLE; m_q[i] = 0; m_ph[i] = 0;
        end else begin
          ns = m_st[i];
          if (ev_ss) begin
            if (m_st[i] == S_IDLE || m_st[i] == S_PAUSED) ns = S_RUN;
            else if (m_st[i] == S_RUN) ns = S_PAUSED;
          end
          if (m_st[i] == S_RUN) m_ph[i] = (m_ph[i] + 1) % P;
          else if (m_st[i] != S_PAUSED) m_ph[i] = 0;
          if (tick) begin
            m_q[i]++;
            if (i == 0 && m_q[i] == 16) begin
              m_q[i] = 0;
              m_cy[i] = 1'b1;
            end else if (i == 1 && m_q[i] == 15) begin
              ns = S_DONE;
            end
          end
          m_st[i] = ns;
        end
      end
    end
  endtask

  // One clock: inputs are stable across the edge, outputs sampled at negedge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; ss_in = 2'b00; clr_in = 2'b00;
    repeat (2) cycle();
    for (int i = 0; i < 2; i++) begin
      tests_run++; if (dq[i] !== 4'd0) begin tests_failed++; $display("FAIL reset_q[%0d]: got %0d expected 0", i, dq[i]); end
      tests_run++; if (dst[i] !== 2'd0) begin tests_failed++; $display("FAIL reset_state[%0d]: got %0d expected 0", i, dst[i]); end
      tests_run++; if (dpause[i] !== 1'b1) begin tests_failed++; $display("FAIL reset_pause[%0d]: got %0d expected 1", i, dpause[i]); end
      tests_run++; if (dcarry[i] !== 1'b0) begin tests_failed++; $display("FAIL reset_carry[%0d]: got %0d expected 0", i, dcarry[i]); end
    end
    rst = 1'b0;
  endtask

  task automatic test_start_count();
    ss_in[0] = 1'b1;
    repeat (5) cycle();
    tests_run++; if (dst[0] !== 2'd0) begin tests_failed++; $display("FAIL start_edge4_state: got %0d expected 0", dst[0]); end
    cycle();
    tests_run++; if (dst[0] !== 2'd1) begin tests_failed++; $display("FAIL start_edge5_state: got %0d expected 1", dst[0]); end
    tests_run++; if (dpause[0] !== 1'b0) begin tests_failed++; $display("FAIL start_edge5_pause: got %0d expected 0", dpause[0]); end
    repeat (3) cycle();
    tests_run++; if (dq[0] !== 4'd0) begin tests_failed++; $display("FAIL start_edge8_q: got %0d expected 0", dq[0]); end
    cycle();
    tests_run++; if (dq[0] !== 4'd1) begin tests_failed++; $display("FAIL start_edge9_q: got %0d expected 1", dq[0]); end
    repeat (4) cycle();
    tests_run++; if (dq[0] !== 4'd2) begin tests_failed++; $display("FAIL start_edge13_q: got %0d expected 2", dq[0]); end
    ss_in[0] = 1'b0;
    repeat (D + 3) cycle();
    tests_run++; if (dst[0] !== 2'd1) begin tests_failed++; $display("FAIL release_no_event: got %0d expected 1", dst[0]); end
  endtask

  task automatic test_pause_resume();
    int qp;
    for (int n = 0; n < P && m_ph[0] != 0; n++) cycle();
    // D+3 RUN edges from phase 0 leave the prescaler 2 cycles into a period.
    ss_in[0] = 1'b1;
    repeat (D + 3) cycle();
    ss_in[0] = 1'b0;
    tests_run++; if (dst[0] !== 2'd2) begin tests_failed++; $display("FAIL pause_state: got %0d expected 2", dst[0]); end
    tests_run++; if (dpause[0] !== 1'b1) begin tests_failed++; $display("FAIL pause_level: got %0d expected 1", dpause[0]); end
    qp = m_q[0];
    tests_run++; if (dq[0] !== 4'(qp)) begin tests_failed++; $display("FAIL pause_q: got %0d expected %0d", dq[0], qp); end
    for (int n = 0; n < 20; n++) begin
      cycle();
      tests_run++; if (dq[0] !== 4'(qp) || dst[0] !== 2'd2) begin tests_failed++; $display("FAIL pause_frozen: got q=%0d st=%0d expected q=%0d st=2", dq[0], dst[0], qp); end
    end
    ss_in[0] = 1'b1;
    repeat (D + 3) cycle();
    ss_in[0] = 1'b0;
    tests_run++; if (dst[0] !== 2'd1) begin tests_failed++; $display("FAIL resume_state: got %0d expected 1", dst[0]); end
    cycle();
    tests_run++; if (dq[0] !== 4'(qp)) begin tests_failed++; $display("FAIL resume_plus1_q: got %0d expected %0d", dq[0], qp); end
    cycle();
    tests_run++; if (dq[0] !== 4'((qp + 1) % 16)) begin tests_failed++; $display("FAIL resume_plus2_q: got %0d expected %0d", dq[0], (qp + 1) % 16); end
    repeat (D + 3) cycle();
  endtask

  task automatic test_wrap();
    int wn;
    for (int n = 0; n < 100 && m_q[0] != 15; n++) cycle();
    wn = 0;
    do begin
      cycle();
      wn++;
    end while (dq[0] == 4'd15 && wn < 2 * P);
    tests_run++; if (wn != P) begin tests_failed++; $display("FAIL wrap_period: got %0d expected %0d", wn, P); end
    tests_run++; if (dq[0] !== 4'd0 || dcarry[0] !== 1'b1) begin tests_failed++; $display("FAIL wrap_edge: got q=%0d carry=%0d expected q=0 carry=1", dq[0], dcarry[0]); end
    cycle();
    tests_run++; if (dcarry[0] !== 1'b0) begin tests_failed++; $display("FAIL wrap_carry_len: got %0d expected 0", dcarry[0]); end
    repeat (3) cycle();
    tests_run++; if (dq[0] !== 4'd1) begin tests_failed++; $display("FAIL wrap_next_q: got %0d expected 1", dq[0]); end
  endtask

  task automatic test_done();
    int n;
    bit carry_seen;
    ss_in[1] = 1'b1;
    repeat (D + 3) cycle();
    ss_in[1] = 1'b0;
    tests_run++; if (dst[1] !== 2'd1) begin tests_failed++; $display("FAIL done_start: got %0d expected 1", dst[1]); end
    n = 0; carry_seen = 1'b0;
    while (n < 100 && dst[1] !== 2'd3) begin
      cycle();
      n++;
      if (dcarry[1] === 1'b1) carry_seen = 1'b1;
    end
    tests_run++; if (n != 15 * P) begin tests_failed++; $display("FAIL done_time: got %0d expected %0d", n, 15 * P); end
    tests_run++; if (dq[1] !== 4'd15 || dst[1] !== 2'd3) begin tests_failed++; $display("FAIL done_q: got q=%0d st=%0d expected q=15 st=3", dq[1], dst[1]); end
    tests_run++; if (carry_seen) begin tests_failed++; $display("FAIL done_carry: got 1 expected 0"); end
    ss_in[1] = 1'b1;
    repeat (D + 3) cycle();
    ss_in[1] = 1'b0;
    repeat (D + 3) cycle();
    tests_run++; if (dq[1] !== 4'd15 || dst[1] !== 2'd3) begin tests_failed++; $display("FAIL done_ss_ignored: got q=%0d st=%0d expected q=15 st=3", dq[1], dst[1]); end
    clr_in[1] = 1'b1;
    repeat (D + 3) cycle();
    clr_in[1] = 1'b0;
    tests_run++; if (dq[1] !== 4'd0 || dst[1] !== 2'd0) begin tests_failed++; $display("FAIL done_clear: got q=%0d st=%0d expected q=0 st=0", dq[1], dst[1]); end
    repeat (D + 3) cycle();
  endtask

  task automatic test_glitch();
    ss_in[0] = 1'b1;
    repeat (2) cycle();
    ss_in[0] = 1'b0;
    repeat (10) cycle();
    tests_run++; if (dst[0] !== 2'd1) begin tests_failed++; $display("FAIL glitch_state: got %0d expected 1", dst[0]); end
  endtask

  task automatic test_simultaneous();
    ss_in[0] = 1'b1; clr_in[0] = 1'b1;
    repeat (D + 3) cycle();
    ss_in[0] = 1'b0; clr_in[0] = 1'b0;
    tests_run++; if (dst[0] !== 2'd0 || dq[0] !== 4'd0 || dcarry[0] !== 1'b0) begin tests_failed++; $display("FAIL simul_clear_wins: got st=%0d q=%0d carry=%0d expected 0 0 0", dst[0], dq[0], dcarry[0]); end
    repeat (D + 3) cycle();
    tests_run++; if (dst[0] !== 2'd0) begin tests_failed++; $display("FAIL simul_settle: got %0d expected 0", dst[0]); end
  endtask

  task automatic test_reset_midrun();
    ss_in[0] = 1'b1;
    repeat (D + 3) cycle();
    ss_in[0] = 1'b0;
    for (int n = 0; n < 100 && m_q[0] != 7; n++) cycle();
    tests_run++; if (dq[0] !== 4'd7 || dst[0] !== 2'd1) begin tests_failed++; $display("FAIL midrun_pre: got q=%0d st=%0d expected q=7 st=1", dq[0], dst[0]); end
    rst = 1'b1;
    cycle();
    tests_run++; if (dq[0] !== 4'd0 || dst[0] !== 2'd0 || dpause[0] !== 1'b1 || dcarry[0] !== 1'b0) begin tests_failed++; $display("FAIL midrun_reset: got q=%0d st=%0d pause=%0d carry=%0d expected 0 0 1 0", dq[0], dst[0], dpause[0], dcarry[0]); end
    cycle();
    rst = 1'b0;
    for (int n = 0; n < 4; n++) begin
      cycle();
      tests_run++; if (dq[0] !== 4'd0 || dst[0] !== 2'd0) begin tests_failed++; $display("FAIL midrun_no_tick: got q=%0d st=%0d expected 0 0", dq[0], dst[0]); end
    end
  endtask

  task automatic test_random();
    int hold [2][2];
    for (int i = 0; i < 2; i++) begin
      hold[i][0] = 0; hold[i][1] = 0;
    end
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (hold[i][0] == 0) begin
          ss_in[i] = 1'($urandom_range(0, 1));
          hold[i][0] = $urandom_range(1, 10);
        end
        if (hold[i][1] == 0) begin
          clr_in[i] = ($urandom_range(0, 9) == 0);
          hold[i][1] = $urandom_range(1, 10);
        end
        hold[i][0]--; hold[i][1]--;
      end
      rst = ($urandom_range(0, 799) == 0);
      cycle();
      for (int i = 0; i < 2; i++) begin
        tests_run++; if (dq[i] !== 4'(m_q[i])) begin tests_failed++; $display("FAIL rand_q[%0d] cyc %0d: got %0d expected %0d", i, c, dq[i], m_q[i]); end
        tests_run++; if (dst[i] !== 2'(m_st[i])) begin tests_failed++; $display("FAIL rand_state[%0d] cyc %0d: got %0d expected %0d", i, c, dst[i], m_st[i]); end
        tests_run++; if (dpause[i] !== (m_st[i] != S_RUN)) begin tests_failed++; $display("FAIL rand_pause[%0d] cyc %0d: got %0d expected %0d", i, c, dpause[i], m_st[i] != S_RUN); end
        tests_run++; if (dcarry[i] !== m_cy[i]) begin tests_failed++; $display("FAIL rand_carry[%0d] cyc %0d: got %0d expected %0d", i, c, dcarry[i], m_cy[i]); end
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_start_count();
    test_pause_resume();
    test_wrap();
    test_done();
    test_glitch();
    test_simultaneous();
    test_reset_midrun();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
